// File: rtl/bp_be_dcache_port_arbiter.sv
// Shares the D$ request port between the exe mem pipe and the PTW. Ptag is steered at accept+1 and early valid at accept+2.
// Backpressure comes from dcache_ready_i; exe is held off while a walk is pending, draining, or owning the port.
module bp_be_dcache_port_arbiter #(
  parameter int pkt_width_p  = 64,
  parameter int ptag_width_p = 28,
  parameter int data_width_p = 64
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    flush_i,
  input  logic                    exe_v_i,
  input  logic [pkt_width_p-1:0]  exe_pkt_i,
  output logic                    exe_ready_o,
  input  logic [ptag_width_p-1:0] exe_ptag_i,
  input  logic                    exe_ptag_v_i,
  input  logic                    exe_ptag_uncached_i,
  output logic                    exe_early_v_o,
  output logic [data_width_p-1:0] exe_early_data_o,
  input  logic                    ptw_req_i,
  output logic                    ptw_grant_o,
  input  logic                    ptw_done_i,
  input  logic                    ptw_v_i,
  input  logic [pkt_width_p-1:0]  ptw_pkt_i,
  output logic                    ptw_ready_o,
  input  logic [ptag_width_p-1:0] ptw_ptag_i,
  input  logic                    ptw_ptag_v_i,
  output logic                    ptw_early_v_o,
  output logic [data_width_p-1:0] ptw_early_data_o,
  output logic                    dcache_v_o,
  output logic [pkt_width_p-1:0]  dcache_pkt_o,
  input  logic                    dcache_ready_i,
  output logic [ptag_width_p-1:0] dcache_ptag_o,
  output logic                    dcache_ptag_v_o,
  output logic                    dcache_ptag_uncached_o,
  input  logic                    dcache_early_v_i,
  input  logic [data_width_p-1:0] dcache_early_data_i
);

  typedef enum logic [1:0] {E_EXE, E_DRAIN, E_PTW} state_e;

  state_e state;
  logic   s1_v, s1_ptw, s2_v, s2_ptw;
  logic   s1_live, s2_live, exe_inflight, accept;

  // A flush kills exe-owned entries in place; walker entries survive it.
  assign s1_live      = s1_v & ~(flush_i & ~s1_ptw);
  assign s2_live      = s2_v & ~(flush_i & ~s2_ptw);
  assign exe_inflight = (s1_live & ~s1_ptw) | (s2_live & ~s2_ptw);

  assign exe_ready_o = ~reset_i & (state == E_EXE) & ~ptw_req_i & ~flush_i & dcache_ready_i;
  assign ptw_grant_o = ~reset_i & (state == E_PTW);
  assign ptw_ready_o = ptw_grant_o & dcache_ready_i;

  always_comb begin
    dcache_v_o   = 1'b0;
    dcache_pkt_o = exe_pkt_i;
    if (state == E_PTW) begin
      dcache_v_o   = ptw_v_i;
      dcache_pkt_o = ptw_pkt_i;
    end else if (state == E_EXE) begin
      dcache_v_o = exe_v_i & ~ptw_req_i & ~flush_i;
    end
    if (reset_i) dcache_v_o = 1'b0;
  end

  assign accept = dcache_v_o & dcache_ready_i;

  always_comb begin
    dcache_ptag_o          = exe_ptag_i;
    dcache_ptag_v_o        = s1_live & exe_ptag_v_i;
    dcache_ptag_uncached_o = s1_live & exe_ptag_uncached_i;
    if (s1_ptw) begin
      dcache_ptag_o          = ptw_ptag_i;
      dcache_ptag_v_o        = s1_live & ptw_ptag_v_i;
      dcache_ptag_uncached_o = 1'b0;
    end
  end

  assign exe_early_v_o    = s2_live & ~s2_ptw & dcache_early_v_i;
  assign ptw_early_v_o    = s2_live &  s2_ptw & dcache_early_v_i;
  assign exe_early_data_o = dcache_early_data_i;
  assign ptw_early_data_o = dcache_early_data_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state  <= E_EXE;
      s1_v   <= 1'b0;
      s1_ptw <= 1'b0;
      s2_v   <= 1'b0;
      s2_ptw <= 1'b0;
    end else begin
      s1_v   <= accept;
      s1_ptw <= (state == E_PTW);
      s2_v   <= s1_live;
      s2_ptw <= s1_ptw;
      unique case (state)
        E_EXE:   if (ptw_req_i)     state <= E_DRAIN;
        E_DRAIN: if (~exe_inflight) state <= E_PTW;
        E_PTW:   if (ptw_done_i)    state <= E_EXE;
        default:                    state <= E_EXE;
      endcase
    end
  end

endmodule
